dot_product_accum: RTL and testbench

- Downstream stage of the dot-product multiplier. It consumes the stream of 39-bit unsigned products and sums a run-time number of them into one result.
- Presents that result on a valid/ready output handshake to the next stage (result store / AXI return logic).
- One accumulation job at a time, started by a start pulse carrying the vector length.

---
 rtl/dot_product_accum.sv | 153 +++++++++++++++
 tb/tb_dot_product_accum.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_accum.sv
// dot_product_accum: sums a run-time number of unsigned products from the
// dot-product multiplier and returns the result on a valid/ready handshake.
// Optional feature macro: DOT_PRODUCT_ACCUM_SAT_EN
//   undefined -> sums wrap modulo 2^ACC_WIDTH, no sat port
//   defined   -> every add saturates at 2^ACC_WIDTH-1 and a sat flag is
//                presented alongside the result
module dot_product_accum #(
  parameter int DIN_WIDTH = 39,
  parameter int LEN_WIDTH = 9,
  parameter int ACC_WIDTH = 47
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic [DIN_WIDTH-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic                 busy,
  output logic [ACC_WIDTH-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready
`ifdef DOT_PRODUCT_ACCUM_SAT_EN
  ,
  output logic                 sat
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [ACC_WIDTH-1:0] dout_q, dout_d;
  logic                 dout_valid_q, dout_valid_d;
  logic [ACC_WIDTH-1:0] sum_next;

`ifdef DOT_PRODUCT_ACCUM_SAT_EN
  logic [ACC_WIDTH:0] sum_full;
  logic               sum_ovf;
  logic               sat_job_q, sat_job_d;
  logic               sat_q, sat_d;

  // Add with one guard bit; a carry out clamps the sum to all ones, so a
  // saturated accumulator stays pinned for the rest of the job.
  always_comb begin
    sum_full = {1'b0, acc_q} + (ACC_WIDTH+1)'(din);
    sum_ovf  = sum_full[ACC_WIDTH];
    sum_next = sum_ovf ? '1 : sum_full[ACC_WIDTH-1:0];
  end
`else
  // Plain modulo-2^ACC_WIDTH add of the zero-extended product.
  always_comb begin
    sum_next = acc_q + ACC_WIDTH'(din);
  end
`endif

  // Next-state and datapath decisions for the IDLE/ACCUM/DONE job flow.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    remaining_d  = remaining_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
`ifdef DOT_PRODUCT_ACCUM_SAT_EN
    sat_job_d    = sat_job_q;
    sat_d        = sat_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef DOT_PRODUCT_ACCUM_SAT_EN
          sat_job_d = 1'b0;
          sat_d     = 1'b0;
`endif
          if (len != '0) begin
            acc_d       = '0;
            remaining_d = len;
            state_d     = ACCUM;
          end else begin
            dout_d       = '0;
            dout_valid_d = 1'b1;
            state_d      = DONE;
          end
        end
      end
      ACCUM: begin
        if (din_valid) begin
          acc_d       = sum_next;
          remaining_d = remaining_q - LEN_WIDTH'(1);
`ifdef DOT_PRODUCT_ACCUM_SAT_EN
          sat_job_d   = sat_job_q | sum_ovf;
`endif
          if (remaining_q == LEN_WIDTH'(1)) begin
            dout_d       = sum_next;
            dout_valid_d = 1'b1;
            state_d      = DONE;
`ifdef DOT_PRODUCT_ACCUM_SAT_EN
            sat_d        = sat_job_q | sum_ovf;
`endif
          end
        end
      end
      DONE: begin
        if (dout_ready) begin
          dout_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset drops any job in flight immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      remaining_q  <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
`ifdef DOT_PRODUCT_ACCUM_SAT_EN
      sat_job_q    <= 1'b0;
      sat_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      remaining_q  <= remaining_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
`ifdef DOT_PRODUCT_ACCUM_SAT_EN
      sat_job_q    <= sat_job_d;
      sat_q        <= sat_d;
`endif
    end
  end

  assign din_ready  = (state_q == ACCUM);
  assign busy       = (state_q != IDLE);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
`ifdef DOT_PRODUCT_ACCUM_SAT_EN
  assign sat        = sat_q;
`endif

endmodule

// File: tb/tb_dot_product_accum.sv
// Testbench for dot_product_accum. The accumulator is built 40 bits wide so
// that three maximal 39-bit products overflow it. Expected results come from
// a plain arithmetic model of each job and are queued at issue time; a
// separate monitor pops and compares whenever a result is handed over.
module tb_dot_product_accum;

  localparam int DIN_W = 39;
  localparam int LEN_W = 9;
  localparam int ACC_W = 40;
  localparam longint unsigned DIN_MAX = (64'd1 << DIN_W) - 64'd1;
  localparam longint unsigned ACC_MAX = (64'd1 << ACC_W) - 64'd1;

  typedef struct packed {
    logic [ACC_W-1:0] value;
    logic             satFlag;
  } expect_t;

  logic             clk;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] lenIn;
  logic [DIN_W-1:0] din;
  logic             dinValid;
  logic             dinReady;
  logic             busy;
  logic [ACC_W-1:0] dout;
  logic             doutValid;
  logic             doutReady;
`ifdef DOT_PRODUCT_ACCUM_SAT_EN
  logic             sat;
`endif

  int      testsRun;
  int      testsFailed;
  expect_t sbQueue[$];

  dot_product_accum #(
    .DIN_WIDTH(DIN_W),
    .LEN_WIDTH(LEN_W),
    .ACC_WIDTH(ACC_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .len(lenIn),
    .din(din),
    .din_valid(dinValid),
    .din_ready(dinReady),
    .busy(busy),
    .dout(dout),
    .dout_valid(doutValid),
    .dout_ready(doutReady)
`ifdef DOT_PRODUCT_ACCUM_SAT_EN
    ,
    .sat(sat)
`endif
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges beyond every local bound.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: count it, and report a miss with both values.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: the result of a job is the true sum of its products,
  // clamped to the accumulator maximum when saturating or reduced modulo
  // 2^ACC_W when wrapping.
  task automatic modelJob(input longint unsigned prods[$], output expect_t res);
    longint unsigned total;
    total = 0;
    foreach (prods[i]) total += prods[i];
`ifdef DOT_PRODUCT_ACCUM_SAT_EN
    if (total > ACC_MAX) begin
      res.value   = ACC_MAX[ACC_W-1:0];
      res.satFlag = 1'b1;
    end else begin
      res.value   = total[ACC_W-1:0];
      res.satFlag = 1'b0;
    end
`else
    res.value   = total[ACC_W-1:0];
    res.satFlag = 1'b0;
`endif
  endtask

  // Monitor: every result handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    expect_t exp;
    if (reset && doutValid && doutReady) begin
      if (sbQueue.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_result: got %0d with nothing queued, required no result", dout);
      end else begin
        exp = sbQueue.pop_front();
        checkOutput("result", 64'(dout), 64'(exp.value));
`ifdef DOT_PRODUCT_ACCUM_SAT_EN
        checkOutput("sat", 64'(sat), 64'(exp.satFlag));
`endif
      end
    end
  end

  // Runs one job from an idle cycle (entered at posedge+1, left at
  // posedge+1 with the block idle again). gap<0 picks random bubbles of
  // 0..2 cycles; poke fires stray start pulses during the hold and in the
  // same cycle as the result handshake, neither of which may start a job.
  task automatic applyStimulus(input int n, input longint unsigned prods[$], input int gap,
                               input int hold, input bit poke);
    expect_t exp;
    int      waitCount;
    int      thisGap;
    modelJob(prods, exp);
    sbQueue.push_back(exp);

    start = 1'b1;
    lenIn = LEN_W'(n);
    @(posedge clk);
    #1 start = 1'b0;

    if (n == 0) begin
      @(negedge clk);
      checkOutput("zero_len_din_ready", 64'(dinReady), 64'd0);
      checkOutput("zero_len_valid", 64'(doutValid), 64'd1);
    end else begin
      @(negedge clk);
      checkOutput("accum_din_ready", 64'(dinReady), 64'd1);
      checkOutput("accum_busy", 64'(busy), 64'd1);
      for (int i = 0; i < n; i++) begin
        dinValid = 1'b1;
        din      = prods[i][DIN_W-1:0];
        waitCount = 0;
        while (!dinReady && waitCount < 50) begin
          @(negedge clk);
          waitCount++;
        end
        if (!dinReady) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL din_ready_timeout: got 0 after 50 cycles, required 1");
        end
        if (i == n - 1) checkOutput("early_valid", 64'(doutValid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        dinValid = 1'b0;
        thisGap = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        if (i < n - 1) repeat (thisGap) @(negedge clk);
      end
      checkOutput("result_latency", 64'(doutValid), 64'd1);
      checkOutput("done_din_ready", 64'(dinReady), 64'd0);
    end

    for (int k = 0; k < hold; k++) begin
      if (poke && k == 1) begin
        start = 1'b1;
        lenIn = LEN_W'(7);
      end
      @(negedge clk);
      start = 1'b0;
      checkOutput("hold_valid", 64'(doutValid), 64'd1);
      checkOutput("hold_dout", 64'(dout), 64'(exp.value));
      checkOutput("hold_din_ready", 64'(dinReady), 64'd0);
    end

    @(posedge clk);
    #1 doutReady = 1'b1;
    if (poke) begin
      start = 1'b1;
      lenIn = LEN_W'(5);
    end
    @(posedge clk);
    #1 doutReady = 1'b0;
    start = 1'b0;
    checkOutput("idle_after_handshake", 64'(busy), 64'd0);
    checkOutput("valid_after_handshake", 64'(doutValid), 64'd0);
  endtask

  // Directed scenarios first, then a batch of random jobs.
  initial begin
    longint unsigned prods[$];
    int n;
    testsRun    = 0;
    testsFailed = 0;
    reset     = 1'b0;
    start     = 1'b0;
    lenIn     = '0;
    din       = '0;
    dinValid  = 1'b0;
    doutReady = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_dout", 64'(dout), 64'd0);
    checkOutput("reset_valid", 64'(doutValid), 64'd0);
    checkOutput("reset_din_ready", 64'(dinReady), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
`ifdef DOT_PRODUCT_ACCUM_SAT_EN
    checkOutput("reset_sat", 64'(sat), 64'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Basic sum of three products.
    prods = '{64'd10, 64'd20, 64'd30};
    applyStimulus(3, prods, 0, 0, 1'b0);
    @(posedge clk);
    #1;

    // Zero-length job.
    prods = {};
    applyStimulus(0, prods, 0, 1, 1'b0);
    @(posedge clk);
    #1;

    // Bubbles of two cycles, five cycles of backpressure, stray starts.
    prods = '{64'd1, 64'd2, 64'd3, 64'd4};
    applyStimulus(4, prods, 2, 5, 1'b1);
    @(posedge clk);
    #1;

    // Reset in the middle of a job discards the partial sum.
    start = 1'b1;
    lenIn = LEN_W'(5);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    dinValid = 1'b1;
    din = DIN_W'(7);
    @(posedge clk);
    @(negedge clk);
    din = DIN_W'(9);
    @(posedge clk);
    @(negedge clk);
    dinValid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checkOutput("midjob_reset_dout", 64'(dout), 64'd0);
    checkOutput("midjob_reset_valid", 64'(doutValid), 64'd0);
    checkOutput("midjob_reset_din_ready", 64'(dinReady), 64'd0);
    checkOutput("midjob_reset_busy", 64'(busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    prods = '{64'd4};
    applyStimulus(1, prods, 0, 0, 1'b0);
    @(posedge clk);
    #1;

    // Three maximal products overflow the 40-bit accumulator.
    prods = '{DIN_MAX, DIN_MAX, DIN_MAX};
    applyStimulus(3, prods, 0, 1, 1'b0);
    @(posedge clk);
    #1;

    // Back-to-back jobs, the second started on the first idle cycle.
    prods = '{64'd5, 64'd6};
    applyStimulus(2, prods, 0, 0, 1'b0);
    prods = '{64'd8};
    applyStimulus(1, prods, 0, 0, 1'b0);

    // Random jobs: mixed lengths, magnitudes, bubbles and backpressure.
    for (int j = 0; j < 30; j++) begin
      n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      prods = {};
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0)
          prods.push_back(64'($urandom_range(0, 1000)));
        else
          prods.push_back({$urandom(), $urandom()} & DIN_MAX);
      end
      applyStimulus(n, prods, -1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", 64'(sbQueue.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
